// File: rtl/mem_stage_sequencer.sv
// MEM-stage access sequencer: runs one load/store against a fixed-latency
// data memory, freezing everything upstream of MEM/WB while it is in flight.
module mem_stage_sequencer #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned AW          = 6
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  input  logic          MEM_R_EN,
  input  logic          MEM_W_EN,
  input  logic [31:0]   ALURes,
  input  logic [31:0]   RMVal,
  input  logic [31:0]   mem_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          freeze,
  output logic          ready,
  output logic [31:0]   rdata_out,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter reload: ACCESS lasts cnt+1 cycles, so load latency minus one.
  localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   stall_q, stall_d;
  logic          req;

  assign req = MEM_R_EN | MEM_W_EN;

  // Next-state, operand capture and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    freeze  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall upstream in the very cycle the request shows up.
        freeze = req;
        if (req) begin
          // Both enables set is treated as a store.
          we_d    = MEM_W_EN;
          // Byte address relative to the window, wrapped to AW word bits.
          addr_d  = AW'((ALURes - BASE_ADDR) >> 2);
          wdata_d = RMVal;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        freeze = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = DONE;
          // mem_rdata is valid on the last access cycle only.
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        // Pipeline advances now, so the same instruction is not re-issued.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall_d = (freeze && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      stall_q <= stall_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Self-checking bench for mem_stage_sequencer: three instances with
// WAIT_CYCLES = 5, 1 and 255 against a transaction-level reference model.
module tb_mem_stage_sequencer;

  localparam int          N    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r_en [N];
  logic        w_en [N];
  logic [31:0] alu  [N];
  logic [31:0] rmv  [N];
  logic [31:0] mrd  [N];
  logic        men  [N];
  logic        mwe  [N];
  logic [5:0]  madr [N];
  logic [31:0] mwd  [N];
  logic        frz  [N];
  logic        rdy  [N];
  logic [31:0] rdo  [N];
  logic [15:0] stc  [N];

  // Device memory (driven by the DUT) and reference memory (driven by the model).
  logic [31:0] dev_mem [N][64];
  logic [31:0] ref_mem [N][64];

  int vectors = 0;
  int errors  = 0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int unsigned W = (gi == 0) ? 5 : (gi == 1) ? 1 : 255;
      mem_stage_sequencer #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .AW(6)) u_dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(r_en[gi]), .MEM_W_EN(w_en[gi]),
        .ALURes(alu[gi]), .RMVal(rmv[gi]), .mem_rdata(mrd[gi]),
        .mem_en(men[gi]), .mem_we(mwe[gi]), .mem_addr(madr[gi]),
        .mem_wdata(mwd[gi]), .freeze(frz[gi]), .ready(rdy[gi]),
        .rdata_out(rdo[gi]), .stall_cnt(stc[gi])
      );
      assign mrd[gi] = dev_mem[gi][madr[gi]];
    end
  endgenerate

  function automatic int w_of(input int k);
    return (k == 0) ? 5 : (k == 1) ? 1 : 255;
  endfunction

  // ---------------- reference model ----------------
  int          stall_exp [N];
  logic [31:0] rdata_exp [N];
  logic [143:0] exp_timing;
  logic [5:0]   exp_idx;
  logic         exp_we;
  logic [31:0]  exp_wd, exp_rdata;
  logic [15:0]  exp_stall;

  task automatic model_txn(input int k, input logic re, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
    int w;
    logic [31:0] off;
    w = w_of(k);
    // freeze cycles 0..W, mem_en 1..W, ready at W+1 (cycle 0 = request seen in IDLE)
    exp_timing = {16'(0), 16'(w), 16'(w + 1), 16'(1), 16'(w), 16'(w),
                  16'(w + 1), 16'(w + 1), 16'(1)};
    off     = a - BASE;
    exp_idx = 6'((off / 32'd4) % 32'd64);
    exp_we  = we;
    exp_wd  = d;
    if (we) ref_mem[k][exp_idx] = d;
    else if (re) rdata_exp[k] = ref_mem[k][exp_idx];
    exp_rdata = rdata_exp[k];
    stall_exp[k] = (stall_exp[k] + w + 1 > 65535) ? 65535 : stall_exp[k] + w + 1;
    exp_stall = 16'(stall_exp[k]);
  endtask

  // ---------------- stimulus / observation ----------------
  logic [143:0] obs_timing;
  logic [5:0]   obs_addr;
  logic         obs_we, obs_stable;
  logic [31:0]  obs_wd, obs_rdata;
  logic [15:0]  obs_stall;

  task automatic run_txn(input int k, input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    int w;
    logic [15:0] ff, fl, fc, ef, el, ec, rf, rl, rc;
    w = w_of(k);
    ff = 16'hFFFF; fl = 0; fc = 0; ef = 16'hFFFF; el = 0; ec = 0;
    rf = 16'hFFFF; rl = 0; rc = 0;
    obs_stable = 1'b1; obs_addr = '0; obs_we = 1'b0; obs_wd = '0;
    @(posedge clk); #1;
    r_en[k] = re; w_en[k] = we; alu[k] = a; rmv[k] = d;
    for (int c = 0; c <= w + 1; c++) begin
      @(negedge clk);
      if (frz[k]) begin if (ff == 16'hFFFF) ff = 16'(c); fl = 16'(c); fc++; end
      if (rdy[k]) begin if (rf == 16'hFFFF) rf = 16'(c); rl = 16'(c); rc++; end
      if (men[k]) begin
        if (ef == 16'hFFFF) begin
          ef = 16'(c); obs_addr = madr[k]; obs_we = mwe[k]; obs_wd = mwd[k];
        end else if (madr[k] != obs_addr || mwe[k] != obs_we || mwd[k] != obs_wd) begin
          obs_stable = 1'b0;
        end
        el = 16'(c); ec++;
        if (mwe[k]) dev_mem[k][madr[k]] = mwd[k];
      end
    end
    obs_timing = {ff, fl, fc, ef, el, ec, rf, rl, rc};
    obs_rdata  = rdo[k];
    obs_stall  = stc[k];
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin r_en[k] = 1'b0; w_en[k] = 1'b0; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      r_en[k] = 1'b0; w_en[k] = 1'b0; alu[k] = '0; rmv[k] = '0;
      stall_exp[k] = 0; rdata_exp[k] = '0;
    end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({men[0], mwe[0], frz[0], rdy[0]} !== 4'b0000 || madr[0] !== 6'd0 ||
        mwd[0] !== 32'd0 || rdo[0] !== 32'd0 || stc[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_state en/we/frz/rdy=%b addr=%0d wd=%h rd=%h st=%0d required all 0",
               {men[0], mwe[0], frz[0], rdy[0]}, madr[0], mwd[0], rdo[0], stc[0]);
    end
    // Get a non-zero rdata_out, then reset in the middle of an ACCESS.
    dev_mem[0][5] = 32'hA5A5_0001; ref_mem[0][5] = 32'hA5A5_0001;
    run_txn(0, 1'b1, 1'b0, BASE + 32'd20, 32'd0);
    model_txn(0, 1'b1, 1'b0, BASE + 32'd20, 32'd0);
    vectors++;
    if (obs_rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL reset_preload rdata act=%h req=%h", obs_rdata, 32'hA5A5_0001);
    end
    @(posedge clk); #1;
    r_en[0] = 1'b1; alu[0] = BASE + 32'd8;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({men[0], mwe[0], rdy[0], frz[0]} !== 4'b0001 || rdo[0] !== 32'd0 ||
        stc[0] !== 16'd0 || madr[0] !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_access en/we/rdy/frz=%b rd=%h st=%0d addr=%0d required 0001/0/0/0",
               {men[0], mwe[0], rdy[0], frz[0]}, rdo[0], stc[0], madr[0]);
    end
    r_en[0] = 1'b0;
    #1;
    vectors++;
    if (frz[0] !== 1'b0) begin
      errors++; $display("FAIL reset_freeze_follows_req act=%b req=0", frz[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin stall_exp[k] = 0; rdata_exp[k] = '0; end
    // FSM must start a fresh, correctly timed access from IDLE.
    run_txn(0, 1'b1, 1'b0, BASE + 32'd20, 32'd0);
    model_txn(0, 1'b1, 1'b0, BASE + 32'd20, 32'd0);
    vectors++;
    if (obs_timing !== exp_timing || obs_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL reset_restart timing=%h rd=%h required timing=%h rd=%h",
               obs_timing, obs_rdata, exp_timing, exp_rdata);
    end
    go_idle();
  endtask

  typedef struct { logic re; logic we; logic [31:0] a; logic [31:0] d; logic [5:0] idx; } dir_t;

  task automatic test_load_store();
    dir_t tbl [5];
    tbl[0] = '{1'b1, 1'b0, 32'd1032, 32'h0,         6'd2};   // load word 2
    tbl[1] = '{1'b0, 1'b1, 32'd1028, 32'h1234_5678, 6'd1};   // store word 1
    tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'hCAFE_0000, 6'd0};   // both -> store word 0
    tbl[3] = '{1'b0, 1'b1, 32'd1020, 32'h0BAD_F00D, 6'd63};  // below base wraps
    tbl[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,         6'd1};   // read back the store
    dev_mem[0][2] = 32'hDEAD_BEEF; ref_mem[0][2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      run_txn(0, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d);
      model_txn(0, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d);
      vectors++;
      if (obs_timing !== exp_timing) begin
        errors++; $display("FAIL ls%0d timing act=%h req=%h", i, obs_timing, exp_timing);
      end
      vectors++;
      if (obs_addr !== tbl[i].idx || obs_stable !== 1'b1) begin
        errors++; $display("FAIL ls%0d addr act=%0d stable=%b req=%0d stable=1", i, obs_addr, obs_stable, tbl[i].idx);
      end
      vectors++;
      if (obs_we !== exp_we || obs_wd !== exp_wd) begin
        errors++; $display("FAIL ls%0d we/wdata act=%b/%h req=%b/%h", i, obs_we, obs_wd, exp_we, exp_wd);
      end
      vectors++;
      if (obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL ls%0d rdata act=%h req=%h", i, obs_rdata, exp_rdata);
      end
      vectors++;
      if (dev_mem[0][tbl[i].idx] !== ref_mem[0][tbl[i].idx]) begin
        errors++; $display("FAIL ls%0d memword act=%h req=%h", i, dev_mem[0][tbl[i].idx], ref_mem[0][tbl[i].idx]);
      end
      go_idle();
    end
    vectors++;
    if (obs_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL ls_readback act=%h req=%h", obs_rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dev_mem[0][2] = 32'h5555_AAAA; ref_mem[0][2] = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      run_txn(0, i == 0, i == 1, (i == 0) ? 32'd1032 : 32'd1036, 32'h7777_0000 + i);
      model_txn(0, i == 0, i == 1, (i == 0) ? 32'd1032 : 32'd1036, 32'h7777_0000 + i);
      vectors++;
      if (obs_timing !== exp_timing || obs_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL b2b%0d timing=%h rd=%h required timing=%h rd=%h",
                 i, obs_timing, obs_rdata, exp_timing, exp_rdata);
      end
    end
    vectors++;
    if (obs_stall !== 16'd12) begin
      errors++; $display("FAIL b2b_stall_cnt act=%0d req=12", obs_stall);
    end
    go_idle();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      alu[0] = $urandom(); rmv[0] = $urandom();
      @(negedge clk);
      vectors++;
      if (frz[0] !== 1'b0 || men[0] !== 1'b0 || stc[0] !== 16'(stall_exp[0])) begin
        errors++;
        $display("FAIL idle c=%0d frz=%b en=%b st=%0d req frz=0 en=0 st=%0d",
                 c, frz[0], men[0], stc[0], stall_exp[0]);
      end
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [1:0]  sel;
    logic [31:0] a, d;
    for (int i = 0; i < n; i++) begin
      sel = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom();
        1: a = BASE - 32'($urandom_range(1, 300));
        default: a = BASE + 32'($urandom_range(0, 1023));
      endcase
      d = $urandom();
      run_txn(k, sel[0], sel[1], a, d);
      model_txn(k, sel[0], sel[1], a, d);
      vectors++;
      if (obs_timing !== exp_timing) begin
        errors++; $display("FAIL rnd k%0d #%0d timing act=%h req=%h", k, i, obs_timing, exp_timing);
      end
      vectors++;
      if (obs_addr !== exp_idx || obs_stable !== 1'b1 || obs_we !== exp_we || obs_wd !== exp_wd) begin
        errors++;
        $display("FAIL rnd k%0d #%0d a=%h addr/stable/we/wd act=%0d/%b/%b/%h req=%0d/1/%b/%h",
                 k, i, a, obs_addr, obs_stable, obs_we, obs_wd, exp_idx, exp_we, exp_wd);
      end
      vectors++;
      if (obs_rdata !== exp_rdata || obs_stall !== exp_stall) begin
        errors++;
        $display("FAIL rnd k%0d #%0d rdata/stall act=%h/%0d req=%h/%0d",
                 k, i, obs_rdata, obs_stall, exp_rdata, exp_stall);
      end
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      run_txn(2, 1'b1, 1'b0, BASE + 32'(4 * (i % 64)), 32'(i));
      model_txn(2, 1'b1, 1'b0, BASE + 32'(4 * (i % 64)), 32'(i));
      vectors++;
      if (obs_timing !== exp_timing || obs_stall !== exp_stall || obs_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL sat #%0d timing=%h st=%0d rd=%h required timing=%h st=%0d rd=%h",
                 i, obs_timing, obs_stall, obs_rdata, exp_timing, exp_stall, exp_rdata);
      end
    end
    vectors++;
    if (obs_stall !== 16'hFFFF) begin
      errors++; $display("FAIL sat_final act=%h req=ffff", obs_stall);
    end
    go_idle();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 64; i++) begin
        dev_mem[k][i] = $urandom();
        ref_mem[k][i] = dev_mem[k][i];
      end
    end
    test_reset();
    test_load_store();
    test_back_to_back();
    test_idle();
    test_random(0, 40);
    test_random(1, 40);
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sequencer.md
# mem_stage_sequencer

Sequencer for the MEM stage of the 5-stage pipeline. It watches the read/write enables and operands leaving the EX/MEM register and runs each load/store against the fixed-latency data memory. While an access is in flight it freezes every pipeline register upstream of MEM/WB, including EX/MEM, and holds the memory address, data and enables stable. It then returns load data with a one-cycle ready pulse so the instruction can advance.

## Interface
- WAIT_CYCLES, 5, data-memory latency in cycles; legal range 1..255.
- BASE_ADDR, 1024, byte address mapped to memory word 0.
- AW, 6, memory word-address width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- MEM_R_EN  in  1  load request from EX/MEM output.
- MEM_W_EN  in  1  store request from EX/MEM output.
- ALURes  in  32  byte address from EX/MEM output.
- RMVal  in  32  store data from EX/MEM output.
- mem_rdata  in  32  data-memory read data; valid on the last access cycle.
- mem_en  out  1  data-memory access enable.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  AW  data-memory word address.
- mem_wdata  out  32  data-memory write data.
- freeze  out  1  stall for all pipeline registers upstream of MEM/WB.
- ready  out  1  one-cycle pulse: access complete, pipeline may advance.
- rdata_out  out  32  last load result, held until the next load completes.
- stall_cnt  out  16  saturating count of cycles with freeze=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- req = MEM_R_EN | MEM_W_EN.
- IDLE:
  - If req=0, stay in IDLE; freeze=0.
  - If req=1, freeze=1 combinationally in the same cycle.
  - At the clock edge with req=1: latch we=MEM_W_EN, mem_addr=((ALURes-BASE_ADDR)>>2)[AW-1:0], mem_wdata=RMVal; load cnt=WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - mem_en=1, mem_we=latched we, freeze=1.
  - Address, write data and we stay stable for the whole state.
  - Each cycle: if cnt≠0, decrement cnt; if cnt==0, go to DONE and, for a load, capture mem_rdata into rdata_out.
- DONE:
  - mem_en=0, freeze=0, ready=1.
  - Always return to IDLE next cycle.
  - The pipeline advances on this cycle, so the same instruction is not restarted.
- MEM_R_EN and MEM_W_EN both 1: treated as a store; rdata_out is unchanged.
- Request inputs are ignored outside IDLE. They are stable anyway because of freeze.
- Address arithmetic:
  - 32-bit subtraction, wrapping modulo 2^32; bits [1:0] dropped, then truncated to AW bits.
  - Out-of-range addresses wrap; no error is raised.
- stall_cnt increments every cycle freeze=1 and saturates at 0xFFFF.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately; cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, ready=0, stall_cnt=0.
  - freeze follows req combinationally while in IDLE.
- Reset during ACCESS:
  - The access is abandoned and mem_en drops without waiting for a clock.
  - rdata_out is cleared, not updated.
- Per access:
  - Request at cycle T: freeze=1 for T..T+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
  - mem_en=1 for T+1..T+WAIT_CYCLES.
  - ready=1 at T+WAIT_CYCLES+1.
  - rdata_out is valid from T+WAIT_CYCLES+1.
- Back-to-back memory instructions: the next request is seen in IDLE at T+WAIT_CYCLES+2, giving one bubble-free DONE cycle between accesses.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle.
- Non-memory instructions: freeze stays 0 and the FSM never leaves IDLE.

## Test plan
- Reset with rst=0 mid-ACCESS (WAIT_CYCLES=5): mem_en, ready and rdata_out are 0 immediately and the FSM is in IDLE; after release with req=0, freeze=0.
- Load with ALURes=1032, memory word 2 = 0xDEADBEEF:
  - freeze high for 6 cycles; mem_addr=2 and mem_en=1 for 5 cycles, mem_we=0.
  - ready pulses once on the 7th cycle; rdata_out=0xDEADBEEF.
- Store with ALURes=1028, RMVal=0x12345678: mem_we=1 and mem_addr=1 for 5 cycles, mem_wdata=0x12345678; rdata_out unchanged; ready pulse.
- Load immediately followed by a store: two 6-cycle freezes separated by exactly one DONE cycle with freeze=0; stall_cnt=12.
- Both enables high, ALURes=1024: store to word 0 performed; rdata_out unchanged. ALURes=1020 (below BASE_ADDR) with AW=6: mem_addr=63.
- 11000 consecutive loads (66000 freeze cycles): stall_cnt saturates at 0xFFFF; WAIT_CYCLES=1 build gives a 2-cycle freeze per access.
